// File: rtl/conv_result_writer.sv
// conv_result_writer
// Write-back sequencer between two CNN layers. Each raw convolution sum is
// passed through ReLU and unsigned saturation. The result is then written to
// the next layer's register file at addresses 0..OUTNUM-1. When the last
// result has been written, Done pulses for one cycle so the next layer can
// start its read pass.
//
// Handshake: a sample transfers on a rising edge where InValid && InReady.
// InReady depends only on the state register: it is high exactly in FILL.
// InValid while InReady is low is ignored. The upstream side may hold or
// drop InValid at any time; nothing is ever back-pressured mid-sample.
module conv_result_writer #(
   parameter int ADDRESS   = 4,
   parameter int DATAWIDTH = 8,
   parameter int DATANUM   = 15,
   parameter int KERNEL    = 3,
   parameter int ACCWIDTH  = 2*DATAWIDTH+2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Start,
   input  logic                 InValid,
   input  logic [ACCWIDTH-1:0]  InData,
   output logic                 InReady,
   output logic                 WriteEn,
   output logic [ADDRESS-1:0]   WriteReg,
   output logic [DATAWIDTH-1:0] WriteData,
   output logic                 Busy,
   output logic                 Done
);

   localparam int OUTNUM = DATANUM - KERNEL + 1;
   localparam logic [ADDRESS-1:0] LAST_INDEX = ADDRESS'(OUTNUM - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [ADDRESS-1:0]   count;
   logic                 accept;
   logic                 last_accept;
   logic [DATAWIDTH-1:0] act_value;

   assign accept      = InValid && InReady;
   assign last_accept = accept && (count == LAST_INDEX);

   // State register; reset aborts any pass in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: FLUSH and DONE each last exactly one cycle
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (Start) state_next = S_FILL;
         S_FILL:  if (last_accept) state_next = S_FLUSH;
         S_FLUSH: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      InReady = 1'b0;
      Busy    = 1'b0;
      Done    = 1'b0;
      case (state)
         S_IDLE:  ;
         S_FILL:  begin InReady = 1'b1; Busy = 1'b1; end
         S_FLUSH: Busy = 1'b1;
         S_DONE:  begin Busy = 1'b1; Done = 1'b1; end
         default: ;
      endcase
   end

   // ReLU followed by unsigned saturation. A negative sum goes to zero.
   // Any set bit above the stored width saturates to all-ones.
   always_comb begin
      act_value = InData[DATAWIDTH-1:0];
      if (InData[ACCWIDTH-1]) begin
         act_value = '0;
      end else if (|InData[ACCWIDTH-2:DATAWIDTH]) begin
         act_value = '1;
      end
   end

   // Accept counter. It is cleared when a pass starts, so a Start seen
   // mid-pass does not disturb the address sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (state == S_IDLE && Start) begin
         count <= '0;
      end else if (accept) begin
         count <= count + 1'b1;
      end
   end

   // Write port: one strobe per accepted sample, on the following cycle.
   // Address and data hold their values between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         WriteEn   <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else begin
         WriteEn <= accept;
         if (accept) begin
            WriteReg  <= count;
            WriteData <= act_value;
         end
      end
   end

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
- Write-side sequencer for a CNN layer. It accepts the stream of raw convolution sums produced from one layer's windowed register-file reads.
- Each sum is passed through ReLU and unsigned saturation, then written to the next layer's register file at sequential addresses 0..OUTNUM-1.
- It completes the read-address → convolve → write-back loop between two layers and signals completion so the next layer can start its read pass.

Parameters:
- ADDRESS, 4, register-file address width; must satisfy OUTNUM <= 2^ADDRESS.
- DATAWIDTH, 8, width of stored (post-activation) data.
- DATANUM, 15, number of input samples held by the source layer.
- KERNEL, 3, convolution window length. Derived localparam OUTNUM = DATANUM-KERNEL+1 (13 by default).
- ACCWIDTH, 2*DATAWIDTH+2, width of the signed convolution sum.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- Start  input  1  begins a write pass; honoured only in IDLE.
- InValid  input  1  InData is a valid convolution sum this cycle.
- InData  input  ACCWIDTH  signed two's-complement convolution sum.
- InReady  output  1  block accepts InData this cycle.
- WriteEn  output  1  write strobe to next-layer register file.
- WriteReg  output  ADDRESS  write address.
- WriteData  output  DATAWIDTH  activated, saturated value.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when all OUTNUM results are written.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; accept counter=0. All outputs 0: InReady, WriteEn, WriteReg, WriteData, Busy, Done. Reset in any state aborts the pass; any partial write count is discarded and no Done is issued.
- FSM states: IDLE, FILL, FLUSH, DONE.
  - IDLE → FILL on Start=1. Start in any other state is ignored (no restart, no counter clear).
  - FILL: InReady=1, registered (InReady = state==FILL).
  - FILL → FLUSH on the edge that accepts the OUTNUM-th sample.
  - FLUSH → DONE unconditionally after one cycle.
  - DONE → IDLE unconditionally after one cycle.
- Accept: a sample is accepted when InValid && InReady at a rising edge. InValid while InReady=0 (IDLE, FLUSH, DONE) is dropped with no side effects. Gaps in InValid during FILL are allowed; the counter holds.
- Activation, applied when the sample is registered:
  - InData < 0 → 0.
  - InData > 2^DATAWIDTH-1 → 2^DATAWIDTH-1 (255).
  - Otherwise the low DATAWIDTH bits of InData.
- Write timing: a sample accepted at edge t produces WriteEn=1 for exactly the cycle following t, with WriteReg = its accept index (0-based) and WriteData = the activated value.
  - WriteEn is 0 in every cycle with no accept on the preceding edge.
  - WriteReg and WriteData hold their last values while WriteEn=0.
- Counter: ADDRESS bits. Increments on each accept, cleared on IDLE→FILL. It never wraps within a pass; at most OUTNUM accepts occur.
- Last sample: accepted at edge E.
  - Cycle after E: state FLUSH, WriteEn=1, WriteReg=OUTNUM-1, InReady=0.
  - Next cycle: state DONE, Done=1, WriteEn=0.
  - Next cycle: IDLE, Busy=0.
- Busy=1 in FILL, FLUSH and DONE. Done=1 only in DONE.
- Start asserted on the same cycle as Done (state DONE) is lost. Upstream must re-issue Start after Busy falls.

Test Plan:
- Back-to-back: Start, then 13 consecutive valid samples with InData=10..22 → WriteEn on 13 consecutive cycles, WriteReg 0..12, WriteData 10..22. Done pulses exactly 2 cycles after the last accept; Busy falls 1 cycle after Done.
- Activation corners: InData = -1, -131072, 0, 255, 256, 131071 → WriteData = 0, 0, 0, 255, 255, 255.
- Gapped input: InValid toggles 1,0,0,1,... across 13 samples → addresses remain contiguous 0..12. No WriteEn on cycles following non-accept edges. Done occurs once.
- Ignored inputs: InValid=1 with InData=99 held in IDLE for 5 cycles → no WriteEn. Start pulsed in FILL after 4 accepts → counter continues, next write uses WriteReg=4.
- Reset mid-operation: rst after the 6th accept → all outputs 0 next cycle, state IDLE, no Done. A new Start plus 13 samples writes addresses from 0.
- Lost Start: Start asserted only during the DONE cycle → block returns to IDLE and stays idle (Busy=0, InReady=0).
